id_fwd_scoreboard: RTL and testbench

- Parametrised hazard/forwarding controller for the ID stage of the dynamic pipeline CPU.
- Replaces the fixed E/M compare logic with a shift-pipeline of in-flight register writes, FWD_STAGES deep.
- Each in-flight write carries a per-instruction "ready stage", so ALU, load and multiplier results share one mechanism.
- Adds a multi-cycle divider busy counter that interlocks HI/LO readers and back-to-back mul/div.

---
 rtl/id_fwd_scoreboard_pkg.sv | 30 +++
 rtl/id_fwd_scoreboard_match.sv | 37 +++
 rtl/id_fwd_scoreboard.sv | 106 ++++++++++
 tb/tb_id_fwd_scoreboard.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_fwd_scoreboard_pkg.sv
// Shared types and constants for the ID-stage forwarding/hazard scoreboard.
// Entry fields use fixed maximum widths so the struct can live here; narrower configs zero-extend.
package id_fwd_scoreboard_pkg;

    localparam int unsigned STG_RF  = 0;
    localparam int unsigned STG_EXE = 1;
    localparam int unsigned STG_MEM = 2;
    localparam int unsigned STG_WB  = 3;

    localparam int unsigned DIV_LAT_DEF = 32;

    localparam int unsigned REG_AW_MAX = 8;
    localparam int unsigned SEL_W_MAX  = 4;

    typedef struct packed {
        logic                  v;
        logic [REG_AW_MAX-1:0] rn;
        logic [SEL_W_MAX-1:0]  rdy;
    } fwd_entry_t;

    // Out-of-range ready stages are treated as the last tracked stage.
    function automatic logic [SEL_W_MAX-1:0] clamp_rdy(input logic [SEL_W_MAX-1:0] rdy,
                                                       input int unsigned          stages);
        if (rdy > SEL_W_MAX'(stages)) begin
            return SEL_W_MAX'(stages);
        end
        return rdy;
    endfunction

endpackage

// File: rtl/id_fwd_scoreboard_match.sv
// Forward-source search for one register operand: youngest matching in-flight
// producer wins; it forwards if it has reached its ready stage, else flags a hazard.
module id_fwd_match
    import id_fwd_scoreboard_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned FWD_STAGES = 3,
    parameter int unsigned SEL_W      = 2
) (
    input  fwd_entry_t [FWD_STAGES-1:0] entries,
    input  logic [REG_AW-1:0]           src,
    input  logic                        use_src,
    output logic [SEL_W-1:0]            sel,
    output logic                        hazard
);

    always_comb begin : search
        logic found;
        sel    = SEL_W'(STG_RF);
        hazard = 1'b0;
        found  = 1'b0;
        if (use_src && (src != '0)) begin
            // entries[k] holds stage k+1, so the lowest index is the youngest producer.
            for (int unsigned k = 0; k < FWD_STAGES; k++) begin
                if (!found && entries[k].v && (entries[k].rn == REG_AW_MAX'(src))) begin
                    found = 1'b1;
                    if (SEL_W_MAX'(k + STG_EXE) >= entries[k].rdy) begin
                        sel = SEL_W'(k + STG_EXE);
                    end else begin
                        hazard = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/id_fwd_scoreboard.sv
// ID-stage hazard/forwarding controller: shift pipeline of in-flight register writes
// with per-instruction ready stage, plus a divider busy counter interlocking HI/LO users.
module id_fwd_scoreboard
    import id_fwd_scoreboard_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned FWD_STAGES = STG_WB,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned DIV_LAT    = DIV_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wreg,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [SEL_W-1:0]  id_ready_stage,
    input  logic              id_is_div,
    input  logic              id_uses_hilo,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_rs_sel,
    output logic [SEL_W-1:0]  fwd_rt_sel,
    output logic              div_busy,
    output logic              div_done
);

    localparam int unsigned CNT_W = $clog2(DIV_LAT + 1);

    if ((REG_AW > REG_AW_MAX) || (SEL_W > SEL_W_MAX) || ((1 << SEL_W) <= FWD_STAGES)
        || (FWD_STAGES < 1)) begin : g_bad_cfg
        $error("id_fwd_scoreboard: unsupported parameter combination");
    end

    fwd_entry_t [FWD_STAGES-1:0] ent_q;
    fwd_entry_t                  new_ent;
    logic [CNT_W-1:0]            div_cnt_q;
    logic                        div_done_q;
    logic                        haz_rs;
    logic                        haz_rt;
    logic                        live;
    logic                        div_issue;

    id_fwd_match #(
        .REG_AW     (REG_AW),
        .FWD_STAGES (FWD_STAGES),
        .SEL_W      (SEL_W)
    ) u_match_rs (
        .entries (ent_q),
        .src     (id_rs),
        .use_src (id_use_rs),
        .sel     (fwd_rs_sel),
        .hazard  (haz_rs)
    );

    id_fwd_match #(
        .REG_AW     (REG_AW),
        .FWD_STAGES (FWD_STAGES),
        .SEL_W      (SEL_W)
    ) u_match_rt (
        .entries (ent_q),
        .src     (id_rt),
        .use_src (id_use_rt),
        .sel     (fwd_rt_sel),
        .hazard  (haz_rt)
    );

    // A flushed instruction is dead: it neither stalls nor enters the pipeline.
    assign live      = id_valid & ~flush;
    assign div_busy  = (div_cnt_q != '0);
    assign div_done  = div_done_q;
    assign stall     = live & ((haz_rs | haz_rt) | ((id_is_div | id_uses_hilo) & div_busy));
    assign div_issue = live & id_is_div & ~stall;

    always_comb begin
        new_ent = '0;
        if (live && id_wreg && (id_rn != '0) && !stall) begin
            new_ent.v   = 1'b1;
            new_ent.rn  = REG_AW_MAX'(id_rn);
            new_ent.rdy = clamp_rdy(SEL_W_MAX'(id_ready_stage), FWD_STAGES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q      <= '0;
            div_cnt_q  <= '0;
            div_done_q <= 1'b0;
        end else begin
            ent_q[0] <= new_ent;
            for (int unsigned k = 1; k < FWD_STAGES; k++) begin
                ent_q[k] <= ent_q[k-1];
            end
            if (div_issue) begin
                div_cnt_q <= CNT_W'(DIV_LAT);
            end else if (div_busy) begin
                div_cnt_q <= div_cnt_q - CNT_W'(1);
            end
            div_done_q <= (div_cnt_q == CNT_W'(1));
        end
    end

endmodule

// File: tb/tb_id_fwd_scoreboard.sv
// Self-checking bench for id_fwd_scoreboard: table-driven per-cycle vectors plus
// hand-written divider sequences; expectations flow through a queue to a negedge monitor.
module tb_id_fwd_scoreboard;

    localparam int unsigned REG_AW     = 5;
    localparam int unsigned FWD_STAGES = 3;
    localparam int unsigned SEL_W      = 2;
    localparam int unsigned DIV_LAT    = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wreg;
    logic [REG_AW-1:0] id_rn;
    logic [SEL_W-1:0]  id_ready_stage;
    logic              id_is_div;
    logic              id_uses_hilo;
    logic              flush;
    logic              stall;
    logic [SEL_W-1:0]  fwd_rs_sel;
    logic [SEL_W-1:0]  fwd_rt_sel;
    logic              div_busy;
    logic              div_done;

    always #5 clk = ~clk;

    id_fwd_scoreboard #(
        .REG_AW     (REG_AW),
        .FWD_STAGES (FWD_STAGES),
        .SEL_W      (SEL_W),
        .DIV_LAT    (DIV_LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_use_rs      (id_use_rs),
        .id_use_rt      (id_use_rt),
        .id_wreg        (id_wreg),
        .id_rn          (id_rn),
        .id_ready_stage (id_ready_stage),
        .id_is_div      (id_is_div),
        .id_uses_hilo   (id_uses_hilo),
        .flush          (flush),
        .stall          (stall),
        .fwd_rs_sel     (fwd_rs_sel),
        .fwd_rt_sel     (fwd_rt_sel),
        .div_busy       (div_busy),
        .div_done       (div_done)
    );

    typedef struct packed {
        logic              rst;
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              use_rs;
        logic              use_rt;
        logic              wreg;
        logic [REG_AW-1:0] rn;
        logic [SEL_W-1:0]  rdy;
        logic              is_div;
        logic              hilo;
        logic              flush;
        logic              x_stall;
        logic [SEL_W-1:0]  x_rs;
        logic [SEL_W-1:0]  x_rt;
        logic              x_busy;
        logic              x_done;
    } vec_t;

    typedef struct packed {
        logic             stall;
        logic [SEL_W-1:0] rs_sel;
        logic [SEL_W-1:0] rt_sel;
        logic             busy;
        logic             done;
        logic [15:0]      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[27];

    function automatic vec_t mk(input bit valid, input int rs, input int rt, input bit urs,
                                input bit urt, input bit wreg, input int rn, input int rdy,
                                input bit hilo, input bit fl, input bit xs, input int xrs,
                                input int xrt);
        vec_t m;
        m         = '0;
        m.valid   = valid;
        m.rs      = REG_AW'(rs);
        m.rt      = REG_AW'(rt);
        m.use_rs  = urs;
        m.use_rt  = urt;
        m.wreg    = wreg;
        m.rn      = REG_AW'(rn);
        m.rdy     = SEL_W'(rdy);
        m.hilo    = hilo;
        m.flush   = fl;
        m.x_stall = xs;
        m.x_rs    = SEL_W'(xrs);
        m.x_rt    = SEL_W'(xrt);
        return m;
    endfunction

    task automatic chk(input string name, input int tag, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s @tag %0d: got %0d, expected %0d", name, tag, act, req);
        end
    endtask

    task automatic apply(input vec_t v, input int tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = v.rst;
        id_valid       = v.valid;
        id_rs          = v.rs;
        id_rt          = v.rt;
        id_use_rs      = v.use_rs;
        id_use_rt      = v.use_rt;
        id_wreg        = v.wreg;
        id_rn          = v.rn;
        id_ready_stage = v.rdy;
        id_is_div      = v.is_div;
        id_uses_hilo   = v.hilo;
        flush          = v.flush;
        e.stall  = v.x_stall;
        e.rs_sel = v.x_rs;
        e.rt_sel = v.x_rt;
        e.busy   = v.x_busy;
        e.done   = v.x_done;
        e.tag    = 16'(tag);
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("stall", int'(e.tag), int'(stall), int'(e.stall));
            chk("fwd_rs_sel", int'(e.tag), int'(fwd_rs_sel), int'(e.rs_sel));
            chk("fwd_rt_sel", int'(e.tag), int'(fwd_rt_sel), int'(e.rt_sel));
            chk("div_busy", int'(e.tag), int'(div_busy), int'(e.busy));
            chk("div_done", int'(e.tag), int'(div_done), int'(e.done));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0;
        id_use_rt = 1'b0; id_wreg = 1'b0; id_rn = '0; id_ready_stage = '0;
        id_is_div = 1'b0; id_uses_hilo = 1'b0; flush = 1'b0;

        //            vld rs  rt  urs urt wr rn  rdy hl fl  xs xrs xrt
        tbl[0]  = mk(0,  3,  3,  1,  1,  0, 0,  0,  0, 0,  0, 0,  0);  // reset state
        tbl[1]  = mk(1,  1,  2,  1,  1,  1, 3,  1,  0, 0,  0, 0,  0);  // add $3
        tbl[2]  = mk(1,  3,  5,  1,  1,  1, 4,  1,  0, 0,  0, 1,  0);  // add $4,$3,$5
        tbl[3]  = mk(1,  6,  3,  1,  1,  1, 0,  1,  0, 0,  0, 0,  2);  // $3 from MEM, rn=0
        tbl[4]  = mk(1,  3,  4,  1,  1,  0, 0,  0,  0, 0,  0, 3,  2);
        tbl[5]  = mk(0,  0,  0,  0,  0,  0, 0,  0,  0, 0,  0, 0,  0);
        tbl[6]  = mk(1,  1,  0,  1,  0,  1, 3,  2,  0, 0,  0, 0,  0);  // lw $3
        tbl[7]  = mk(1,  1,  3,  1,  1,  1, 8,  1,  0, 0,  1, 0,  0);  // load-use stall
        tbl[8]  = mk(1,  1,  3,  1,  1,  1, 8,  1,  0, 0,  0, 0,  2);
        tbl[9]  = mk(1,  3,  8,  1,  1,  0, 0,  0,  0, 0,  0, 3,  1);  // one bubble only
        tbl[10] = mk(1,  0,  0,  0,  0,  1, 3,  1,  0, 0,  0, 0,  0);
        tbl[11] = mk(1,  0,  0,  0,  0,  1, 3,  1,  0, 0,  0, 0,  0);
        tbl[12] = mk(1,  3,  0,  1,  0,  0, 0,  0,  0, 0,  0, 1,  0);  // youngest wins
        tbl[13] = mk(1,  0,  0,  0,  0,  1, 3,  2,  0, 0,  0, 0,  0);
        tbl[14] = mk(1,  3,  0,  1,  0,  0, 0,  0,  0, 0,  1, 0,  0);  // young not ready
        tbl[15] = mk(1,  3,  0,  1,  0,  0, 0,  0,  0, 0,  0, 2,  0);
        tbl[16] = mk(1,  0,  3,  0,  1,  0, 0,  0,  0, 0,  0, 0,  3);  // past ready stage
        tbl[17] = mk(1,  0,  0,  1,  1,  1, 0,  1,  0, 0,  0, 0,  0);  // add $0
        tbl[18] = mk(1,  0,  0,  1,  1,  0, 0,  0,  0, 0,  0, 0,  0);
        tbl[19] = mk(1,  1,  0,  1,  0,  1, 3,  2,  0, 0,  0, 0,  0);  // lw $3
        tbl[20] = mk(1,  1,  3,  1,  1,  1, 9,  1,  0, 1,  0, 0,  0);  // flushed dependent
        tbl[21] = mk(1,  9,  3,  1,  1,  0, 0,  0,  0, 0,  0, 0,  2);
        tbl[22] = mk(1,  0,  0,  0,  0,  1, 10, 3,  0, 0,  0, 0,  0);  // rdy=WB producer
        tbl[23] = mk(1,  10, 0,  1,  0,  0, 0,  0,  0, 0,  1, 0,  0);
        tbl[24] = mk(1,  10, 0,  1,  0,  0, 0,  0,  0, 0,  1, 0,  0);
        tbl[25] = mk(1,  10, 0,  1,  0,  0, 0,  0,  0, 0,  0, 3,  0);
        tbl[26] = mk(1,  0,  0,  0,  0,  0, 0,  0,  1, 0,  0, 0,  0);  // hilo, divider idle

        repeat (3) @(posedge clk);
        for (int i = 0; i < 27; i++) begin
            apply(tbl[i], i);
        end

        // Divider issue, then mfhi two cycles later.
        v = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        v.is_div = 1'b1;
        apply(v, 100);
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.x_busy = 1'b1;
        apply(v, 101);
        for (int c = 2; c <= 33; c++) begin
            v = mk(1, 0, 0, 0, 0, 1, 11, 1, 1, 0, (c <= 32), 0, 0);
            v.x_busy = (c <= 32);
            v.x_done = (c == 33);
            apply(v, 100 + c);
        end
        apply(mk(1, 11, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), 134);

        // Reset while the divider counts 10: no done pulse, entries dropped.
        v = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        v.is_div = 1'b1;
        apply(v, 200);
        for (int c = 1; c <= 21; c++) begin
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            v.x_busy = 1'b1;
            apply(v, 200 + c);
        end
        v = mk(1, 0, 0, 0, 0, 1, 12, 1, 0, 0, 0, 0, 0);
        v.x_busy = 1'b1;
        apply(v, 222);
        v = mk(1, 12, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        v.x_busy = 1'b1;
        v.rst = 1'b1;
        apply(v, 223);
        apply(mk(1, 12, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 224);
        for (int c = 25; c <= 36; c++) begin
            apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 200 + c);
        end

        repeat (3) @(posedge clk);
        chk("queue_drain", 0, exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
